// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: symbol codes, the active-low GFEDCBA pattern table,
// scan-decoder FSM states and the anode-select helper.
package seg7_pkg;

  localparam logic [3:0] CODE_DASH = 4'd10;
  localparam logic [3:0] CODE_A    = 4'd11;
  localparam logic [3:0] CODE_C    = 4'd12;
  localparam logic [3:0] CODE_DARK = 4'd13;
  localparam logic [3:0] CODE_BAD  = 4'd15;

  localparam int NUM_PAT = 14;

  // Entry i is the pattern a driver emits for code i.
  localparam logic [NUM_PAT-1:0][6:0] SEG_TABLE = {
    7'b1111111, 7'b1000110, 7'b0001000, 7'b0111111,
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010,
    7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100,
    7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HELD} scan_state_e;

  // Returns {legal, position}; only single-zero selects are legal.
  function automatic logic [2:0] digit_sel(input logic [3:0] d);
    case (d)
      4'b1110: digit_sel = 3'b100;
      4'b1101: digit_sel = 3'b101;
      4'b1011: digit_sel = 3'b110;
      4'b0111: digit_sel = 3'b111;
      default: digit_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low GFEDCBA pattern to its symbol code;
// unknown patterns yield CODE_BAD with bad_o set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] code_o,
  output logic       bad_o
);

  always_comb begin
    code_o = CODE_BAD;
    bad_o  = 1'b1;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (pat_i == SEG_TABLE[4'(i)]) begin
        code_o = 4'(i);
        bad_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four-digit frames from a multiplexed seven-segment drive: debounces each
// (anode, segment) dwell, decodes it into a slot, and publishes the frame once all four slots are fresh.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  DIGIT,
  input  logic [6:0]  DISPLAY,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_err,
  output logic        stale
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [3:0]      d_q, pd_q;
  logic [6:0]      s_q, ps_q;
  scan_state_e     state_q;
  logic [7:0]      cnt_q;
  logic [3:0][3:0] slot_q;
  logic [3:0]      seen_q;
  logic [15:0]     frame_q;
  logic            frame_valid_q, changed_q, seg_err_q, done_q;
  logic [TW-1:0]   to_q;

  logic       blank, chg, cap;
  logic [2:0] sel;
  logic [1:0] sel_pos;
  logic [3:0] cap_bit, seen_d, dec_code;
  logic       dec_bad;

  seg7_pattern_decode u_dec (
    .pat_i  (s_q),
    .code_o (dec_code),
    .bad_o  (dec_bad)
  );

  assign blank   = (d_q == 4'hF);
  assign chg     = ({d_q, s_q} != {pd_q, ps_q});
  assign sel     = digit_sel(d_q);
  assign sel_pos = sel[1:0];
  assign cap_bit = 4'b0001 << sel_pos;
  // A publish cycle empties seen before this cycle's capture is merged in.
  assign seen_d  = done_q ? 4'b0000 : seen_q;

  // Capture fires on the sample that brings the dwell length to STABLE_CYC.
  assign cap = !blank && (chg ? (STABLE_CYC == 1)
                              : (state_q == ST_SETTLE && cnt_q == 8'(STABLE_CYC - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q           <= 4'hF;
      pd_q          <= 4'hF;
      s_q           <= 7'h7F;
      ps_q          <= 7'h7F;
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      slot_q        <= {4{CODE_DARK}};
      seen_q        <= '0;
      frame_q       <= 16'hDDDD;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      seg_err_q     <= 1'b0;
      done_q        <= 1'b0;
      to_q          <= '0;
    end else begin
      d_q  <= DIGIT;
      s_q  <= DISPLAY;
      pd_q <= d_q;
      ps_q <= s_q;

      if (blank) begin
        state_q <= ST_WAIT;
        cnt_q   <= '0;
      end else if (chg) begin
        cnt_q   <= 8'd1;
        state_q <= cap ? ST_HELD : ST_SETTLE;
      end else if (state_q == ST_SETTLE) begin
        cnt_q <= cnt_q + 8'd1;
        if (cap) state_q <= ST_HELD;
      end

      seg_err_q <= 1'b0;
      done_q    <= 1'b0;
      seen_q    <= seen_d;
      if (cap) begin
        seg_err_q <= !sel[2] || dec_bad;
        if (sel[2]) begin
          slot_q[sel_pos] <= dec_code;
          seen_q          <= seen_d | cap_bit;
          done_q          <= ((seen_d | cap_bit) == 4'hF);
        end
      end

      frame_valid_q <= done_q;
      changed_q     <= 1'b0;
      if (done_q) begin
        frame_q   <= slot_q;
        changed_q <= (slot_q != frame_q);
        to_q      <= '0;
      end else if (to_q != TW'(TIMEOUT_CYC)) begin
        to_q <= to_q + TW'(1);
      end
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign changed     = changed_q;
  assign seg_err     = seg_err_q;
  assign stale       = (to_q == TW'(TIMEOUT_CYC));

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench: scans hand-built digit sequences through the decoder and checks frames,
// pulse counts, the stale timeout and reset behaviour against hand-computed values.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  digit = 4'hF;
  logic [6:0]  display = 7'h7F;
  logic [15:0] frame;
  logic        frame_valid, changed, seg_err, stale;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0, chg_cnt = 0, err_cnt = 0;
  logic stale_at_fv = 1'b1;
  int fv0, chg0, err0;

  localparam logic [6:0] P_DASH = 7'b0111111;
  localparam logic [6:0] P_C    = 7'b1000110;
  localparam logic [6:0] P_DARK = 7'b1111111;
  localparam logic [6:0] P_A    = 7'b0001000;
  localparam logic [6:0] P_0    = 7'b1000000;
  localparam logic [6:0] P_1    = 7'b1111001;
  localparam logic [6:0] P_2    = 7'b0100100;
  localparam logic [6:0] P_3    = 7'b0110000;
  localparam logic [6:0] P_5    = 7'b0010010;
  localparam logic [6:0] P_7    = 7'b1111000;
  localparam logic [6:0] P_8    = 7'b0000000;
  localparam logic [6:0] P_9    = 7'b0010000;
  localparam logic [6:0] P_BAD  = 7'b1010101;

  seg7_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .DIGIT       (digit),
    .DISPLAY     (display),
    .frame       (frame),
    .frame_valid (frame_valid),
    .changed     (changed),
    .seg_err     (seg_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt      <= fv_cnt + 1;
      stale_at_fv <= stale;
    end
    if (changed) chg_cnt <= chg_cnt + 1;
    if (seg_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits on a negedge; drives the pair and holds it for n cycles.
  task automatic drive(input logic [3:0] d, input logic [6:0] p, input int n);
    digit   = d;
    display = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int pos, input logic [6:0] p, input bit glitch);
    logic [3:0] one;
    one = 4'b0001;
    if (glitch) drive(4'hF ^ (one << pos), P_BAD, 2);
    drive(4'hF ^ (one << pos), p, 8);
  endtask

  task automatic mark;
    fv0  = fv_cnt;
    chg0 = chg_cnt;
    err0 = err_cnt;
  endtask

  task automatic idle;
    drive(4'hF, 7'h7F, 4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_frame", 32'(frame), 32'hDDDD);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_changed", 32'(changed), 0);
    chk("rst_seg_err", 32'(seg_err), 0);
    chk("rst_stale", 32'(stale), 0);
    rst = 1'b0;

    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("stale_at_99", 32'(stale), 0);
    @(posedge clk);
    @(negedge clk);
    chk("stale_at_100", 32'(stale), 1);
    idle();
    chk("stale_held", 32'(stale), 1);

    mark();
    for (int p = 3; p >= 0; p--) show(p, P_DASH, 1'b0);
    idle();
    chk("dash_frame", 32'(frame), 32'hAAAA);
    chk("dash_fv", 32'(fv_cnt - fv0), 1);
    chk("dash_changed", 32'(chg_cnt - chg0), 1);
    chk("dash_stale_in_fv", 32'(stale_at_fv), 0);
    chk("dash_stale_after", 32'(stale), 0);

    mark();
    for (int p = 3; p >= 0; p--) show(p, P_DASH, 1'b0);
    idle();
    chk("rep_frame", 32'(frame), 32'hAAAA);
    chk("rep_fv", 32'(fv_cnt - fv0), 1);
    chk("rep_changed", 32'(chg_cnt - chg0), 0);

    mark();
    show(3, P_C, 1'b1);
    show(2, P_DARK, 1'b1);
    show(1, P_0, 1'b1);
    show(0, P_5, 1'b1);
    idle();
    chk("glitch_frame", 32'(frame), 32'hCD05);
    chk("glitch_err", 32'(err_cnt - err0), 0);
    chk("glitch_fv", 32'(fv_cnt - fv0), 1);
    chk("glitch_changed", 32'(chg_cnt - chg0), 1);

    mark();
    show(3, P_1, 1'b0);
    show(2, P_2, 1'b0);
    show(1, P_3, 1'b0);
    drive(4'b1100, P_0, 10);
    chk("illegal_err", 32'(err_cnt - err0), 1);
    chk("illegal_no_fv", 32'(fv_cnt - fv0), 0);
    show(0, P_BAD, 1'b0);
    idle();
    chk("badpat_err", 32'(err_cnt - err0), 2);
    chk("badpat_fv", 32'(fv_cnt - fv0), 1);
    chk("badpat_frame", 32'(frame), 32'h123F);

    mark();
    show(0, P_7, 1'b0);
    show(1, P_8, 1'b0);
    show(2, P_9, 1'b0);
    rst = 1'b1;
    drive(4'hF, 7'h7F, 2);
    chk("mid_rst_frame", 32'(frame), 32'hDDDD);
    chk("mid_rst_fv", 32'(frame_valid), 0);
    chk("mid_rst_stale", 32'(stale), 0);
    rst = 1'b0;
    show(3, P_A, 1'b0);
    idle();
    chk("post_rst_no_fv", 32'(fv_cnt - fv0), 0);
    show(2, P_9, 1'b0);
    show(1, P_8, 1'b0);
    show(0, P_7, 1'b0);
    idle();
    chk("post_rst_fv", 32'(fv_cnt - fv0), 1);
    chk("post_rst_frame", 32'(frame), 32'hB987);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
